// File: rtl/pid_mux_sched_if.sv
// Shared-multiplier bus between the PI scheduler (master) and an external
// combinational Q4.28 multiplier (slave).
interface pid_mux_sched_if;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_p;

  modport master (output mul_a, output mul_b, input mul_p);
  modport slave  (input mul_a, input mul_b, output mul_p);
endinterface

// File: rtl/pid_mux_sched.sv
// Time-shared PI controller: NCH channels updated in sequence through one
// external Q4.28 multiplier, four cycles per channel.
module pid_mux_sched #(
  parameter int          NCH  = 4,
  parameter logic [31:0] KP   = 32'h1000_0000,
  parameter logic [31:0] KI   = 32'h1000_0000,
  parameter logic [31:0] VMIN = 32'h0010_0000,
  parameter logic [31:0] VMAX = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NCH*32-1:0] xref,
  input  logic [NCH*32-1:0] xf,
  pid_mux_sched_if.master   mul,
  output logic              busy,
  output logic              done,
  output logic [NCH*32-1:0] vc
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_ACC, S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_ch;
  logic [31:0]     r_e;
  logic [31:0]     r_p;
  logic [31:0]     r_i;
  logic [31:0]     r_xref_s [NCH];
  logic [31:0]     r_xf_s   [NCH];
  logic [31:0]     r_vint   [NCH];
  logic [31:0]     r_vc     [NCH];
  logic [NCH-1:0]  r_clamp;
  logic [31:0]     r_mul_a;
  logic [31:0]     r_mul_b;
  logic            r_busy;
  logic            r_done;

  logic [31:0]     w_e;
  logic [31:0]     w_vintNew;
  logic [31:0]     w_vcont;
  logic [31:0]     w_vcSat;
  logic            w_clampNext;
  logic            w_lastCh;

  assign w_e      = r_xref_s[r_ch] - r_xf_s[r_ch];
  assign w_lastCh = (r_ch == CW'(NCH - 1));

  always_comb begin
    w_vintNew = r_vint[r_ch] + r_i;
    w_vcont   = w_vintNew + r_p;
    w_vcSat   = w_vcont;
    if ($signed(w_vcont) >= $signed(VMAX))
      w_vcSat = VMAX;
    else if ($signed(w_vcont) <= $signed(VMIN))
      w_vcSat = VMIN;
    w_clampNext = ($signed(w_vcSat) > $signed(VMIN)) &&
                  ($signed(w_vcSat) < $signed(VMAX));
  end

  // Operands are registered one state ahead so they are stable for the
  // whole MUL_P / MUL_I cycle in which the product is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_e     <= '0;
      r_p     <= '0;
      r_i     <= '0;
      r_clamp <= '1;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_vint[k] <= '0;
        r_vc[k]   <= VMIN;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < NCH; k++) begin
              r_xref_s[k] <= xref[32*k +: 32];
              r_xf_s[k]   <= xf[32*k +: 32];
            end
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          r_e     <= w_e;
          r_mul_a <= KP;
          r_mul_b <= w_e;
          r_state <= S_MUL_P;
        end
        S_MUL_P: begin
          r_p     <= mul.mul_p;
          r_mul_a <= r_clamp[r_ch] ? KI : 32'h0;
          r_mul_b <= r_e;
          r_state <= S_MUL_I;
        end
        S_MUL_I: begin
          r_i     <= mul.mul_p;
          r_mul_a <= '0;
          r_mul_b <= '0;
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_vint[r_ch]  <= w_vintNew;
          r_vc[r_ch]    <= w_vcSat;
          r_clamp[r_ch] <= w_clampNext;
          if (w_lastCh) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= S_ERR;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mul.mul_a = r_mul_a;
  assign mul.mul_b = r_mul_b;
  assign busy      = r_busy;
  assign done      = r_done;

  for (genvar k = 0; k < NCH; k++) begin : g_vc
    assign vc[32*k +: 32] = r_vc[k];
  end

endmodule

// File: tb/tb_pid_mux_sched.sv
// Directed bench for pid_mux_sched with an ideal signed Q4.28 multiplier.
module tb_pid_mux_sched;
  localparam int          NCH  = 4;
  localparam logic [31:0] KP   = 32'h1000_0000;
  localparam logic [31:0] KI   = 32'h1000_0000;
  localparam logic [31:0] VMIN = 32'h0010_0000;
  localparam logic [31:0] VMAX = 32'h4000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NCH*32-1:0] xref;
  logic [NCH*32-1:0] xf;
  logic              busy;
  logic              done;
  logic [NCH*32-1:0] vc;

  pid_mux_sched_if mif ();

  logic signed [63:0] w_prod;
  assign w_prod    = $signed(mif.mul_a) * $signed(mif.mul_b);
  assign mif.mul_p = w_prod[59:28];

  pid_mux_sched #(
    .NCH(NCH), .KP(KP), .KI(KI), .VMIN(VMIN), .VMAX(VMAX)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .xref  (xref),
    .xf    (xf),
    .mul   (mif.master),
    .busy  (busy),
    .done  (done),
    .vc    (vc)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  logic [31:0] aLog [1:18];
  logic [31:0] bLog [1:18];
  logic        doneLog [1:18];
  logic        busyLog [1:18];
  int          doneCycle;
  int          doneCount;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one full pass from IDLE and logs outputs for cycles 1..18.
  task automatic run_pass();
    doneCycle = -1;
    doneCount = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      aLog[c]    = mif.mul_a;
      bLog[c]    = mif.mul_b;
      doneLog[c] = done;
      busyLog[c] = busy;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (c < 18) tick();
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] r, input logic [31:0] f);
    xref[32*k +: 32] = r;
    xf[32*k +: 32]   = f;
  endtask

  task automatic test_reset();
    start = 1'b1;
    rst   = 1'b1;
    tick();
    for (int k = 0; k < NCH; k++) begin
      tests++;
      if (vc[32*k +: 32] !== VMIN) begin
        errors++;
        $display("[TB] FAIL reset_vc%0d got %h want %h", k, vc[32*k +: 32], VMIN);
      end
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
    end
    tests++;
    if (mif.mul_a !== 32'h0 || mif.mul_b !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mul got a=%h b=%h want 0 0", mif.mul_a, mif.mul_b);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_over_start got busy=%b want 0", busy);
    end
    start = 1'b0;
    rst   = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    xref = '0;
    xf   = '0;
    set_ch(0, 32'h0100_0000, 32'h0080_0000);
    run_pass();
    tests++;
    if (doneCycle !== 17 || doneCount !== 1) begin
      errors++;
      $display("[TB] FAIL basic_done got cycle=%0d count=%0d want 17 1", doneCycle, doneCount);
    end
    tests++;
    if (busyLog[1] !== 1'b1 || busyLog[17] !== 1'b1 || busyLog[18] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy got %b%b%b want 110", busyLog[1], busyLog[17], busyLog[18]);
    end
    tests++;
    if (aLog[2] !== KP || bLog[2] !== 32'h0080_0000) begin
      errors++;
      $display("[TB] FAIL basic_mulp got a=%h b=%h want %h 00800000", aLog[2], bLog[2], KP);
    end
    tests++;
    if (aLog[1] !== 32'h0 || aLog[4] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL basic_mul_idle got err=%h acc=%h want 0 0", aLog[1], aLog[4]);
    end
    tests++;
    if (vc[31:0] !== 32'h0100_0000) begin
      errors++;
      $display("[TB] FAIL basic_vc0_p1 got %h want 01000000", vc[31:0]);
    end
    tests++;
    if (vc[63:32] !== VMIN) begin
      errors++;
      $display("[TB] FAIL basic_vc1_p1 got %h want %h", vc[63:32], VMIN);
    end
    run_pass();
    tests++;
    if (vc[31:0] !== 32'h0180_0000) begin
      errors++;
      $display("[TB] FAIL basic_vc0_p2 got %h want 01800000", vc[31:0]);
    end
  endtask

  task automatic test_clamp_high();
    do_reset();
    xref = '0;
    xf   = '0;
    set_ch(1, 32'h3000_0000, 32'h0);
    run_pass();
    tests++;
    if (aLog[7] !== KI) begin
      errors++;
      $display("[TB] FAIL high_muli_p1 got %h want %h", aLog[7], KI);
    end
    tests++;
    if (vc[63:32] !== VMAX || dut.r_clamp[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL high_p1 got vc1=%h clamp=%b want %h 0", vc[63:32], dut.r_clamp[1], VMAX);
    end
    run_pass();
    tests++;
    if (aLog[7] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL high_muli_p2 got %h want 0", aLog[7]);
    end
    tests++;
    if (dut.r_vint[1] !== 32'h3000_0000 || vc[63:32] !== VMAX) begin
      errors++;
      $display("[TB] FAIL high_p2 got vint1=%h vc1=%h want 30000000 %h", dut.r_vint[1], vc[63:32], VMAX);
    end
  endtask

  task automatic test_clamp_low();
    do_reset();
    xref = '0;
    xf   = '0;
    set_ch(2, 32'h0, 32'h0080_0000);
    run_pass();
    tests++;
    if (bLog[10] !== 32'hFF80_0000) begin
      errors++;
      $display("[TB] FAIL low_err got %h want ff800000", bLog[10]);
    end
    tests++;
    if (dut.r_vint[2] !== 32'hFF80_0000) begin
      errors++;
      $display("[TB] FAIL low_vint got %h want ff800000", dut.r_vint[2]);
    end
    tests++;
    if (vc[95:64] !== VMIN || dut.r_clamp[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL low_vc2 got vc2=%h clamp=%b want %h 0", vc[95:64], dut.r_clamp[2], VMIN);
    end
  endtask

  task automatic test_start_held();
    int firstDone;
    int secondDone;
    int cnt;
    logic busy18;
    logic busy19;
    do_reset();
    firstDone  = -1;
    secondDone = -1;
    cnt        = 0;
    busy18     = 1'bx;
    busy19     = 1'bx;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 45; c++) begin
      if (c == 20) start = 1'b0;
      if (done) begin
        cnt++;
        if (firstDone < 0) firstDone = c;
        else if (secondDone < 0) secondDone = c;
      end
      if (c == 18) busy18 = busy;
      if (c == 19) busy19 = busy;
      tick();
    end
    tests++;
    if (cnt !== 2) begin
      errors++;
      $display("[TB] FAIL held_count got %0d want 2", cnt);
    end
    tests++;
    if (firstDone !== 17 || secondDone !== 35) begin
      errors++;
      $display("[TB] FAIL held_cycles got %0d %0d want 17 35", firstDone, secondDone);
    end
    tests++;
    if (busy18 !== 1'b0 || busy19 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_busy got %b%b want 01", busy18, busy19);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    do_reset();
    xref = '0;
    xf   = '0;
    set_ch(0, 32'h0100_0000, 32'h0080_0000);
    run_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_flags got busy=%b done=%b want 0 0", busy, done);
    end
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) cnt++;
      tick();
    end
    tests++;
    if (cnt !== 0) begin
      errors++;
      $display("[TB] FAIL mid_nodone got %0d pulses want 0", cnt);
    end
    for (int k = 0; k < NCH; k++) begin
      tests++;
      if (vc[32*k +: 32] !== VMIN || dut.r_vint[k] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL mid_clear%0d got vc=%h vint=%h want %h 0", k, vc[32*k +: 32], dut.r_vint[k], VMIN);
      end
    end
    run_pass();
    tests++;
    if (vc[31:0] !== 32'h0100_0000 || doneCycle !== 17) begin
      errors++;
      $display("[TB] FAIL mid_rerun got vc0=%h done=%0d want 01000000 17", vc[31:0], doneCycle);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    xref  = '0;
    xf    = '0;
    tick();
    test_reset();
    test_basic();
    test_clamp_high();
    test_clamp_low();
    test_start_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
